// File: rtl/trace_capture.sv
// trace_capture: triggered probe capture into a column-addressed sample RAM with dual registered display reads
module trace_capture #(
  parameter int data_width = 20,
  parameter int depth      = 1280,
  parameter int addr_width = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] probe,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [data_width-1:0] trig_mask,
  input  logic [data_width-1:0] trig_value,
  input  logic [7:0]            sample_div,
  input  logic [addr_width-1:0] x,
  output logic [data_width-1:0] state,
  output logic [data_width-1:0] buf_data,
  output logic                  armed,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} fsm_e;
  fsm_e fsm_q, fsm_d;
  logic [addr_width-1:0] waddr_q, waddr_d, wa, xl;
  logic [7:0] div_q, div_d, hold_q, hold_d;
  logic [data_width-1:0] mem [depth];
  logic [data_width-1:0] state_q, buf_q;
  logic we, hit, tick, in_rng;
  assign hit = ((probe ^ trig_value) & trig_mask) == '0;
  assign tick = div_q == hold_q;
  assign in_rng = 32'(x) < depth;
  assign xl = (x == '0) ? '0 : x - addr_width'(1);
  always_comb begin
    fsm_d = fsm_q;
    waddr_d = waddr_q;
    div_d = div_q;
    hold_d = hold_q;
    we = 1'b0;
    wa = waddr_q;
    if (abort) fsm_d = IDLE;
    else if ((fsm_q == IDLE || fsm_q == DONE) && arm) fsm_d = ARMED;
    else if (fsm_q == ARMED && hit) begin
      fsm_d = CAPTURE;
      we = 1'b1;
      wa = '0;
      waddr_d = addr_width'(1);
      div_d = '0;
      hold_d = sample_div;
    end else if (fsm_q == CAPTURE) begin
      div_d = tick ? '0 : div_q + 8'd1;
      we = tick;
      waddr_d = tick ? waddr_q + addr_width'(1) : waddr_q;
      fsm_d = (tick && waddr_q == addr_width'(depth - 1)) ? DONE : CAPTURE;
    end
  end
  always_ff @(posedge clk) if (we) mem[wa] <= probe;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= IDLE;
      waddr_q <= '0;
      div_q <= '0;
      hold_q <= '0;
      state_q <= '0;
      buf_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      waddr_q <= waddr_d;
      div_q <= div_d;
      hold_q <= hold_d;
      state_q <= in_rng ? mem[x] : '0;
      buf_q <= in_rng ? mem[xl] : '0;
    end
  end
  assign state = state_q;
  assign buf_data = buf_q;
  assign armed = fsm_q == ARMED;
  assign busy = fsm_q == CAPTURE;
  assign done = fsm_q == DONE;
endmodule
